multi_clock_gen: RTL and testbench

Parametrised multi-channel clock/strobe generator, the successor to the fixed-ratio clock generator under the board top level. Divides the single 12.09 MHz internal-oscillator clock into NUM_CH independent outputs. Each channel has a runtime-programmable period, a square or strobe mode, glitch-free period changes, and a common phase-realignment input. Consumers are the DMX timing, LED refresh and frame-rate logic, which use either the square output or the one-cycle tick.

---
 rtl/multi_clock_gen.sv | 125 ++++++++++++
 tb/tb_multi_clock_gen.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_clock_gen.sv
// multi_clock_gen: NUM_CH programmable clock/strobe dividers off one clock.
// Shadowed period/mode updates land on wrap or sync, so no runt phases.
module multi_clock_gen #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 24,
  parameter logic [NUM_CH*DIV_W-1:0] DEF_DIV =
    {24'd302250, 24'd403000, 24'd48, 24'd12090000},
  parameter logic [NUM_CH-1:0] DEF_MODE = {NUM_CH{1'b0}}
) (
  input  logic              clk_In,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_mode,
  input  logic              sync,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pend
);

  logic [NUM_CH-1:0][DIV_W-1:0] per_q, per_d;
  logic [NUM_CH-1:0][DIV_W-1:0] shd_per_q, shd_per_d;
  logic [NUM_CH-1:0][DIV_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0] mode_q, mode_d;
  logic [NUM_CH-1:0] shd_mode_q, shd_mode_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] run_q, run_d;
  logic [NUM_CH-1:0] clk_q, clk_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] wr_sel, en_q, wrap;

  assign clk_out = clk_q;
  assign tick    = tick_q;
  assign pend    = pend_q;

  // Per-channel write select, enable and wrap (run_q=0 means restart)
  always_comb begin
    wr_sel = '0;
    en_q   = '0;
    wrap   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_sel[i] = cfg_we && (32'(cfg_ch) == i);
      en_q[i]   = per_q[i] > DIV_W'(1);
      wrap[i]   = !run_q[i] ||
                  (cnt_q[i] == per_q[i] - DIV_W'(1));
    end
  end

  // Next-state: apply config on sync/wrap/disabled, decode outputs
  always_comb begin
    per_d      = per_q;
    mode_d     = mode_q;
    shd_per_d  = shd_per_q;
    shd_mode_d = shd_mode_q;
    pend_d     = pend_q;
    cnt_d      = cnt_q;
    run_d      = run_q;
    clk_d      = '0;
    tick_d     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sync || (en_q[i] && wrap[i])) begin
        if (wr_sel[i]) begin
          per_d[i]      = cfg_div;
          mode_d[i]     = cfg_mode;
          shd_per_d[i]  = cfg_div;
          shd_mode_d[i] = cfg_mode;
        end else if (pend_q[i]) begin
          per_d[i]  = shd_per_q[i];
          mode_d[i] = shd_mode_q[i];
        end
        pend_d[i] = 1'b0;
        cnt_d[i]  = '0;
        run_d[i]  = per_d[i] > DIV_W'(1);
      end else if (!en_q[i]) begin
        if (wr_sel[i]) begin
          per_d[i]      = cfg_div;
          mode_d[i]     = cfg_mode;
          shd_per_d[i]  = cfg_div;
          shd_mode_d[i] = cfg_mode;
        end
        cnt_d[i] = '0;
        run_d[i] = 1'b0;
      end else begin
        cnt_d[i] = cnt_q[i] + DIV_W'(1);
        if (wr_sel[i]) begin
          shd_per_d[i]  = cfg_div;
          shd_mode_d[i] = cfg_mode;
          pend_d[i]     = 1'b1;
        end
      end
      if (run_d[i] && (per_d[i] > DIV_W'(1))) begin
        tick_d[i] = cnt_d[i] == '0;
        clk_d[i]  = mode_d[i] ? (cnt_d[i] == '0)
                              : (cnt_d[i] < (per_d[i] >> 1));
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clk_In) begin
    if (rst) begin
      per_q      <= DEF_DIV;
      mode_q     <= DEF_MODE;
      shd_per_q  <= DEF_DIV;
      shd_mode_q <= DEF_MODE;
      pend_q     <= '0;
      cnt_q      <= '0;
      run_q      <= '0;
      clk_q      <= '0;
      tick_q     <= '0;
    end else begin
      per_q      <= per_d;
      mode_q     <= mode_d;
      shd_per_q  <= shd_per_d;
      shd_mode_q <= shd_mode_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      run_q      <= run_d;
      clk_q      <= clk_d;
      tick_q     <= tick_d;
    end
  end

endmodule

// File: tb/tb_multi_clock_gen.sv
// tb_multi_clock_gen: directed + random stimulus against a
// phase-arithmetic model (phase = cycles since channel start, mod P).
module tb_multi_clock_gen;
  localparam int NCH = 4;
  localparam int DW  = 24;

  logic clk_In = 1'b0;
  logic rst = 1'b1;
  logic cfg_we = 1'b0;
  logic [3:0] cfg_ch = '0;
  logic [DW-1:0] cfg_div = '0;
  logic cfg_mode = 1'b0;
  logic sync = 1'b0;
  logic [NCH-1:0] clk_out, tick, pend;

  int checks = 0;
  int errors = 0;

  always #5 clk_In = ~clk_In;

  multi_clock_gen dut (
    .clk_In(clk_In), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_mode(cfg_mode), .sync(sync),
    .clk_out(clk_out), .tick(tick), .pend(pend)
  );

  // model: active P/M, shadow, pend, and start cycle S of phase 0
  int def_p[NCH] = '{12090000, 48, 403000, 302250};
  int P[NCH], M[NCH], SP[NCH], SM[NCH], PD[NCH];
  longint S[NCH];
  longint n = 0;
  int rc = 0;
  bit chk_en = 1'b0;
  logic [NCH-1:0] exp_clk, exp_tick, exp_pend;
  logic [NCH-1:0] nx_clk, nx_tick, nx_pend;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d rc=%0d got=%0h want=%0h",
               nm, n, rc, act, want);
    end
  endtask

  task automatic model(input bit r, input bit we, input int ch,
                       input int div, input bit md, input bit sy);
    for (int c = 0; c < NCH; c++) begin
      longint d;
      longint ph;
      bit en;
      bit wr;
      bit wp;
      if (r) begin
        P[c] = def_p[c]; M[c] = 0;
        SP[c] = def_p[c]; SM[c] = 0;
        PD[c] = 0; S[c] = n + 2;
      end else begin
        en = P[c] >= 2;
        d  = n + 1 - S[c];
        wr = we && (ch == c);
        wp = en && (d >= 0) && ((d % P[c]) == 0);
        if (sy || wp) begin
          if (wr) begin P[c] = div; M[c] = int'(md); end
          else if (PD[c] != 0) begin P[c] = SP[c]; M[c] = SM[c]; end
          PD[c] = 0;
          S[c] = n + 1;
        end else if (!en) begin
          if (wr) begin P[c] = div; M[c] = int'(md); S[c] = n + 2; end
        end else if (wr) begin
          SP[c] = div; SM[c] = int'(md); PD[c] = 1;
        end
      end
      ph = n + 1 - S[c];
      nx_tick[c] = 1'b0;
      nx_clk[c]  = 1'b0;
      if (P[c] >= 2 && ph >= 0) begin
        ph = ph % P[c];
        nx_tick[c] = (ph == 0);
        nx_clk[c]  = (M[c] != 0) ? (ph == 0) : (ph < P[c] / 2);
      end
      nx_pend[c] = PD[c] != 0;
    end
  endtask

  // drive one cycle, compare at negedge, advance to next cycle
  task automatic cyc(input bit r, input bit we, input int ch,
                     input int div, input bit md, input bit sy);
    rst = r; cfg_we = we; cfg_ch = 4'(ch);
    cfg_div = DW'(div); cfg_mode = md; sync = sy;
    model(r, we, ch, div, md, sy);
    @(negedge clk_In);
    if (chk_en) begin
      check("clk_out", 32'(clk_out), 32'(exp_clk));
      check("tick", 32'(tick), 32'(exp_tick));
      check("pend", 32'(pend), 32'(exp_pend));
    end
    @(posedge clk_In);
    #1;
    exp_clk = nx_clk; exp_tick = nx_tick; exp_pend = nx_pend;
    chk_en = 1'b1;
    n++;
    rc = r ? 0 : rc + 1;
  endtask

  task automatic idle(input int k);
    repeat (k) cyc(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int hi;
    int tk;
    int mm;
    @(posedge clk_In);
    #1;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    check("rst_clk", 32'(clk_out), 32'h0);
    check("rst_tick", 32'(tick), 32'h0);
    check("rst_pend", 32'(pend), 32'h0);

    hi = 0;
    for (int k = 1; k <= 100; k++) begin
      idle(1);
      if (rc <= 48) hi += int'(clk_out[1]);
      if (rc == 1) check("c1_tick_all", 32'(tick), 32'hF);
      if (rc == 48) check("c48_tick1", 32'(tick[1]), 32'h0);
      if (rc == 49) check("c49_tick1", 32'(tick[1]), 32'h1);
      if (rc == 49) check("model_c49", 32'(exp_tick[1]), 32'h1);
      if (rc == 97) check("c97_tick1", 32'(tick[1]), 32'h1);
    end
    check("ch1_high48", hi, 24);

    cyc(0, 1, 1, 5, 0, 0);
    check("pend1_set", 32'(pend[1]), 32'h1);
    idle(60);
    hi = 0; tk = 0;
    for (int k = 0; k < 5; k++) begin
      idle(1);
      hi += int'(clk_out[1]);
      tk += int'(tick[1]);
    end
    check("odd5_high", hi, 2);
    check("odd5_tick", tk, 1);

    cyc(0, 1, 1, 5, 1, 0);
    idle(12);
    tk = 0; mm = 0;
    for (int k = 0; k < 5; k++) begin
      idle(1);
      tk += int'(tick[1]);
      if (clk_out[1] != tick[1]) mm++;
    end
    check("strobe_tick", tk, 1);
    check("strobe_eq", mm, 0);

    cyc(0, 1, 3, 7, 0, 0);
    check("pend3_set", 32'(pend[3]), 32'h1);
    cyc(0, 1, 0, 6, 0, 1);
    check("sync_tick", 32'(tick), 32'hF);
    check("sync_pend", 32'(pend), 32'h0);
    idle(5);
    check("p6_early", 32'(tick[0]), 32'h0);
    idle(1);
    check("p6_tick", 32'(tick[0]), 32'h1);

    cyc(0, 1, 2, 0, 0, 1);
    check("dis_tick", 32'(tick), 32'hB);
    idle(3);
    cyc(0, 1, 2, 4, 0, 0);
    check("en_t1", 32'(tick[2]), 32'h0);
    idle(1);
    check("en_t2", 32'(tick[2]), 32'h1);
    idle(4);
    check("en_t6", 32'(tick[2]), 32'h1);

    cyc(0, 1, 7, 3, 1, 0);
    check("bad_ch_pend", 32'(pend), 32'h0);

    cyc(0, 1, 3, 9, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    check("mrst_pend", 32'(pend), 32'h0);
    check("mrst_tick", 32'(tick), 32'h0);
    idle(1);
    check("mrst_c1", 32'(tick), 32'hF);

    for (int k = 0; k < 4000; k++) begin
      bit r;
      bit we;
      bit md;
      bit sy;
      int ch;
      int dv;
      r  = $urandom_range(0, 499) == 0;
      we = $urandom_range(0, 5) == 0;
      ch = int'($urandom_range(0, 7));
      dv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1))
                                        : int'($urandom_range(2, 20));
      md = $urandom_range(0, 1) == 1;
      sy = $urandom_range(0, 39) == 0;
      cyc(r, we, ch, dv, md, sy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
